// File: rtl/fpu_wb_cmd_master.sv
// Wishbone classic initiator that runs one FPU operation per command:
// operand writes, launch, status poll, result/flag readback, valid clear.
module fpu_wb_cmd_master #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          ACK_TIMEOUT = 255,
    parameter int          POLL_LIMIT  = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [31:0] cmd_c,
    input  logic [2:0]  cmd_rm,
    input  logic [11:0] cmd_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_flags,
    output logic        rsp_err,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam logic [31:0] OFF_A   = 32'h00;
    localparam logic [31:0] OFF_B   = 32'h04;
    localparam logic [31:0] OFF_C   = 32'h08;
    localparam logic [31:0] OFF_RES = 32'h0C;
    localparam logic [31:0] OFF_FLG = 32'h10;
    localparam logic [31:0] OFF_OP  = 32'h1C;
    localparam logic [31:0] OFF_STS = 32'h20;
    localparam logic [31:0] OFF_RM  = 32'h24;

    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_WR_C,
        S_WR_RM,
        S_WR_OP,
        S_POLL,
        S_RD_RES,
        S_RD_FLG,
        S_WR_CLR,
        S_RESP
    } state_t;

    state_t         r_state;
    logic           r_stb;
    logic           r_we;
    logic [3:0]     r_sel;
    logic [31:0]    r_adr;
    logic [31:0]    r_dat;
    logic [TW-1:0]  r_tmo;
    logic [PW-1:0]  r_poll;
    logic [31:0]    r_b;
    logic [31:0]    r_c;
    logic [2:0]     r_rm;
    logic [11:0]    r_op;
    logic [31:0]    r_result;
    logic [4:0]     r_flags;
    logic           r_err;
    logic           r_rsp_valid;

    state_t         w_state_n;
    state_t         w_tgt;
    logic           w_stb_n;
    logic [TW-1:0]  w_tmo_n;
    logic [PW-1:0]  w_poll_n;
    logic [31:0]    w_res_n;
    logic [4:0]     w_flg_n;
    logic           w_err_n;
    logic           w_rv_n;
    logic           w_ld;
    logic           w_start;
    logic           w_abort;
    logic           w_set_we;
    logic [31:0]    w_set_adr;
    logic [31:0]    w_set_dat;

    function automatic state_t f_succ(input state_t s);
        case (s)
            S_WR_A:   f_succ = S_WR_B;
            S_WR_B:   f_succ = S_WR_C;
            S_WR_C:   f_succ = S_WR_RM;
            S_WR_RM:  f_succ = S_WR_OP;
            S_WR_OP:  f_succ = S_POLL;
            S_POLL:   f_succ = S_RD_RES;
            S_RD_RES: f_succ = S_RD_FLG;
            S_RD_FLG: f_succ = S_WR_CLR;
            S_WR_CLR: f_succ = S_RESP;
            default:  f_succ = S_IDLE;
        endcase
    endfunction

    // WR_A only ever starts on the accept cycle, so it drives cmd_a directly.
    always_comb begin
        w_set_we  = 1'b0;
        w_set_adr = BASE_ADDR;
        w_set_dat = 32'h0;
        unique case (w_tgt)
            S_WR_A: begin
                w_set_we  = 1'b1;
                w_set_adr = BASE_ADDR + OFF_A;
                w_set_dat = cmd_a;
            end
            S_WR_B: begin
                w_set_we  = 1'b1;
                w_set_adr = BASE_ADDR + OFF_B;
                w_set_dat = r_b;
            end
            S_WR_C: begin
                w_set_we  = 1'b1;
                w_set_adr = BASE_ADDR + OFF_C;
                w_set_dat = r_c;
            end
            S_WR_RM: begin
                w_set_we  = 1'b1;
                w_set_adr = BASE_ADDR + OFF_RM;
                w_set_dat = {29'b0, r_rm};
            end
            S_WR_OP: begin
                w_set_we  = 1'b1;
                w_set_adr = BASE_ADDR + OFF_OP;
                w_set_dat = {19'b0, 1'b1, r_op};
            end
            S_POLL: begin
                w_set_adr = BASE_ADDR + OFF_STS;
            end
            S_RD_RES: begin
                w_set_adr = BASE_ADDR + OFF_RES;
            end
            S_RD_FLG: begin
                w_set_adr = BASE_ADDR + OFF_FLG;
            end
            S_WR_CLR: begin
                w_set_we  = 1'b1;
                w_set_adr = BASE_ADDR + OFF_OP;
                w_set_dat = {19'b0, 1'b0, r_op};
            end
            default: begin
                w_set_we  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_tgt     = r_state;
        w_stb_n   = r_stb;
        w_tmo_n   = r_tmo;
        w_poll_n  = r_poll;
        w_res_n   = r_result;
        w_flg_n   = r_flags;
        w_err_n   = r_err;
        w_rv_n    = r_rsp_valid;
        w_ld      = 1'b0;
        w_start   = 1'b0;
        w_abort   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_ld      = 1'b1;
                    w_start   = 1'b1;
                    w_tgt     = S_WR_A;
                    w_state_n = S_WR_A;
                    w_err_n   = 1'b0;
                    w_poll_n  = '0;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_n = S_IDLE;
                    w_rv_n    = 1'b0;
                end
            end
            default: begin
                if (!r_stb) begin
                    w_start = 1'b1;
                end else if (wbm_ack_i) begin
                    w_stb_n   = 1'b0;
                    w_state_n = f_succ(r_state);
                    case (r_state)
                        S_POLL: begin
                            if (!wbm_dat_i[0]) begin
                                w_poll_n = r_poll + 1'b1;
                                if (r_poll == PW'(POLL_LIMIT - 1))
                                    w_abort = 1'b1;
                                else
                                    w_state_n = S_POLL;
                            end
                        end
                        S_RD_RES: w_res_n = wbm_dat_i;
                        S_RD_FLG: w_flg_n = wbm_dat_i[4:0];
                        S_WR_CLR: w_rv_n  = 1'b1;
                        default:  w_rv_n  = r_rsp_valid;
                    endcase
                end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
                    w_abort = 1'b1;
                end else begin
                    w_tmo_n = r_tmo + 1'b1;
                end
            end
        endcase
        // Aborts skip the remaining transfers, including the valid clear.
        if (w_abort) begin
            w_stb_n   = 1'b0;
            w_state_n = S_RESP;
            w_err_n   = 1'b1;
            w_res_n   = 32'h0;
            w_flg_n   = 5'h0;
            w_rv_n    = 1'b1;
        end
        if (w_start) begin
            w_stb_n = 1'b1;
            w_tmo_n = '0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_IDLE;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'h0;
            r_adr       <= 32'h0;
            r_dat       <= 32'h0;
            r_tmo       <= '0;
            r_poll      <= '0;
            r_b         <= 32'h0;
            r_c         <= 32'h0;
            r_rm        <= 3'h0;
            r_op        <= 12'h0;
            r_result    <= 32'h0;
            r_flags     <= 5'h0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_stb       <= w_stb_n;
            r_sel       <= w_stb_n ? 4'hF : 4'h0;
            r_tmo       <= w_tmo_n;
            r_poll      <= w_poll_n;
            r_result    <= w_res_n;
            r_flags     <= w_flg_n;
            r_err       <= w_err_n;
            r_rsp_valid <= w_rv_n;
            if (w_start) begin
                r_we  <= w_set_we;
                r_adr <= w_set_adr;
                r_dat <= w_set_dat;
            end else if (!w_stb_n) begin
                r_we  <= 1'b0;
                r_adr <= 32'h0;
                r_dat <= 32'h0;
            end
            if (w_ld) begin
                r_b  <= cmd_b;
                r_c  <= cmd_c;
                r_rm <= cmd_rm;
                r_op <= cmd_op;
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE) && !wb_rst_i;
    assign busy       = (r_state != S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign rsp_err    = r_err;
    assign wbm_cyc_o  = r_stb;
    assign wbm_stb_o  = r_stb;
    assign wbm_we_o   = r_we;
    assign wbm_sel_o  = r_sel;
    assign wbm_adr_o  = r_adr;
    assign wbm_dat_o  = r_dat;

endmodule

// File: tb/tb_fpu_wb_cmd_master.sv
// Scoreboard bench for fpu_wb_cmd_master: expected bus transfers and
// responses are queued by the stimulus and popped by monitors.
module tb_fpu_wb_cmd_master;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int TMO  = 255;
    localparam int PLIM = 1023;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_a, cmd_b, cmd_c;
    logic [2:0]  cmd_rm;
    logic [11:0] cmd_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic        rsp_err, busy;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;

    always #5 clk = ~clk;

    fpu_wb_cmd_master dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_c     (cmd_c),
        .cmd_rm    (cmd_rm),
        .cmd_op    (cmd_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          ab;
    } bus_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        logic        err;
        int          lat;
    } rsp_t;

    bus_t bq[$];
    rsp_t rq[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;
    int g_hs     = 0;
    int resp_hs  = 0;

    // Slave model
    int          sl_delay    = 0;
    logic        sl_spur     = 1'b0;
    logic [31:0] sl_noack    = 32'hFFFF_FFFF;
    int          sl_polls    = 0;
    int          sl_ready_at = 0;
    logic [31:0] sl_result   = 32'h0;
    logic [31:0] sl_flags    = 32'h0;
    int          sl_wait     = 0;
    logic        w_sack;

    assign w_sack = wbm_cyc_o && wbm_stb_o && (sl_wait >= sl_delay)
                    && (wbm_adr_o != sl_noack);
    assign wbm_ack_i = w_sack || (sl_spur && !wbm_stb_o);
    assign wbm_dat_i =
        (wbm_adr_o == BASE + 32'h20) ?
            ((sl_polls >= sl_ready_at) ? 32'h0000_0001 : 32'hFFFF_FFFE) :
        (wbm_adr_o == BASE + 32'h0C) ? sl_result :
        (wbm_adr_o == BASE + 32'h10) ? sl_flags : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (wbm_stb_o && !w_sack) sl_wait <= sl_wait + 1;
        else sl_wait <= 0;
        if (w_sack && !wbm_we_o && wbm_adr_o == BASE + 32'h20)
            sl_polls <= sl_polls + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input int a, input int r);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0d, required %0d", nm, a, r);
    endtask

    // Bus monitor
    int run = 0;
    always @(negedge clk) begin
        #2;
        if (wbm_stb_o) begin
            if (bq.size() == 0) begin
                fail_now("bus_unexpected_cycle", 1, 0);
            end else begin
                chk("bus_adr", wbm_adr_o, bq[0].adr);
                chk("bus_we", {31'b0, wbm_we_o}, {31'b0, bq[0].we});
                chk("bus_sel", {28'b0, wbm_sel_o}, 32'hF);
                chk("bus_cyc", {31'b0, wbm_cyc_o}, 32'h1);
                if (bq[0].we) chk("bus_dat", wbm_dat_o, bq[0].dat);
                if (wbm_ack_i) begin
                    n_checks++;
                    if (bq[0].ab != 0) begin
                        n_errors++;
                        $display("FAIL bus_ack: transfer completed, required abandon kind %0d",
                                 bq[0].ab);
                    end
                    void'(bq.pop_front());
                    run = 0;
                end else begin
                    run++;
                end
            end
        end else if (run > 0) begin
            if (bq.size() > 0) begin
                n_checks++;
                if (bq[0].ab == 0) begin
                    n_errors++;
                    $display("FAIL bus_drop: stb dropped without ack, required completion");
                end
                if (bq[0].ab == 1) chk("stb_timeout_cycles", run, TMO);
                void'(bq.pop_front());
            end
            run = 0;
        end
    end

    // Response monitor
    bit seen = 1'b0;
    always @(negedge clk) begin
        #2;
        if (busy) chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'h0);
        if (rsp_valid) begin
            if (rq.size() == 0) begin
                fail_now("rsp_unexpected", 1, 0);
            end else begin
                chk("rsp_result", rsp_result, rq[0].res);
                chk("rsp_flags", {27'b0, rsp_flags}, {27'b0, rq[0].flg});
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, rq[0].err});
                if (!seen) begin
                    seen = 1'b1;
                    if (rq[0].lat >= 0)
                        chk("rsp_latency", cyc_cnt - g_hs, rq[0].lat);
                end
                if (rsp_ready) begin
                    void'(rq.pop_front());
                    seen = 1'b0;
                    resp_hs = cyc_cnt + 1;
                end
            end
        end
    end

    task automatic pb(input logic we, input logic [31:0] off,
                      input logic [31:0] dat, input int ab);
        bus_t e;
        e.we = we; e.adr = BASE + off; e.dat = dat; e.ab = ab;
        bq.push_back(e);
    endtask

    task automatic pr(input logic [31:0] res, input logic [4:0] flg,
                      input logic err, input int lat);
        rsp_t e;
        e.res = res; e.flg = flg; e.err = err; e.lat = lat;
        rq.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] a, b, c, rmd, opd);
        pb(1, 32'h00, a, 0);
        pb(1, 32'h04, b, 0);
        pb(1, 32'h08, c, 0);
        pb(1, 32'h24, rmd, 0);
        pb(1, 32'h1C, opd, 0);
    endtask

    task automatic push_seq(input logic [31:0] a, b, c, rmd, opd, clrd,
                            input int npoll, input logic [31:0] res,
                            input logic [4:0] flg, input int lat);
        push_wr(a, b, c, rmd, opd);
        repeat (npoll) pb(0, 32'h20, 32'h0, 0);
        pb(0, 32'h0C, 32'h0, 0);
        pb(0, 32'h10, 32'h0, 0);
        pb(1, 32'h1C, clrd, 0);
        pr(res, flg, 1'b0, lat);
    endtask

    task automatic send_cmd(input logic [31:0] a, b, c,
                            input logic [2:0] rm, input logic [11:0] op);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a = a; cmd_b = b; cmd_c = c; cmd_rm = rm; cmd_op = op;
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            fail_now("cmd_accept_timeout", n, 0);
            cmd_valid = 1'b0;
            return;
        end
        g_hs = cyc_cnt + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (n < 6000) begin
            @(negedge clk);
            #3;
            if (bq.size() == 0 && rq.size() == 0 && !busy && !rsp_valid)
                break;
            n++;
        end
        n_checks++;
        if (n >= 6000) begin
            n_errors++;
            $display("FAIL %s_done: bus=%0d rsp=%0d pending, required 0",
                     nm, bq.size(), rq.size());
            $display("Simulation finished: %0d checks, %0d errors",
                     n_checks, n_errors);
            $finish;
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end

    initial begin
        int n;
        wb_rst_i = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        cmd_a = 0; cmd_b = 0; cmd_c = 0; cmd_rm = 0; cmd_op = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        wb_rst_i = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_cmd_ready_idle", {31'b0, cmd_ready}, 32'h1);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_stb", {31'b0, wbm_stb_o}, 32'h0);
        chk("rst_cyc", {31'b0, wbm_cyc_o}, 32'h0);
        chk("rst_sel", {28'b0, wbm_sel_o}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("rst_rsp_result", rsp_result, 32'h0);

        // Nominal divide, zero wait states
        sl_result = 32'h3FC0_0000; sl_flags = 32'h0;
        sl_ready_at = sl_polls;
        push_seq(32'h4040_0000, 32'h4000_0000, 32'h0, 32'h0,
                 32'h0000_1010, 32'h0000_0010, 1,
                 32'h3FC0_0000, 5'h00, 17);
        send_cmd(32'h4040_0000, 32'h4000_0000, 32'h0, 3'd0, 12'h010);
        wait_done("nominal");

        // Wait states, spurious idle acks, two not-ready polls
        sl_delay = 3; sl_spur = 1'b1;
        sl_flags = 32'hFFFF_FFE5;
        sl_ready_at = sl_polls + 2;
        push_seq(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                 32'h0000_0003, 32'h0000_1ABC, 32'h0000_0ABC, 3,
                 32'h3FC0_0000, 5'h05, -1);
        send_cmd(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                 3'd3, 12'hABC);
        wait_done("waitstate");
        sl_delay = 0; sl_spur = 1'b0; sl_flags = 32'h0;

        // Ack timeout on WR_B
        sl_noack = BASE + 32'h04;
        pb(1, 32'h00, 32'h1111_1111, 0);
        pb(1, 32'h04, 32'h2222_2222, 1);
        pr(32'h0, 5'h00, 1'b1, -1);
        send_cmd(32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                 3'd1, 12'h020);
        wait_done("timeout");
        repeat (20) @(negedge clk);
        sl_noack = 32'hFFFF_FFFF;

        // Poll limit
        sl_ready_at = sl_polls + 100000;
        push_wr(32'h5, 32'h6, 32'h7, 32'h0000_0002, 32'h0000_1001);
        repeat (PLIM) pb(0, 32'h20, 32'h0, 0);
        pr(32'h0, 5'h00, 1'b1, -1);
        send_cmd(32'h5, 32'h6, 32'h7, 3'd2, 12'h001);
        wait_done("poll_limit");
        sl_ready_at = sl_polls;

        // Response backpressure with a second command pending
        sl_flags = 32'h0000_0001;
        push_seq(32'hA, 32'hB, 32'hC, 32'h0000_0004, 32'h0000_1123,
                 32'h0000_0123, 1, 32'h3FC0_0000, 5'h01, -1);
        push_seq(32'hD, 32'hE, 32'hF, 32'h0000_0007, 32'h0000_1FFF,
                 32'h0000_0FFF, 1, 32'h3FC0_0000, 5'h01, -1);
        fork
            begin
                send_cmd(32'hA, 32'hB, 32'hC, 3'd4, 12'h123);
                send_cmd(32'hD, 32'hE, 32'hF, 3'd7, 12'hFFF);
            end
            begin
                rsp_ready = 1'b0;
                n = 0;
                while (!rsp_valid && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                repeat (10) @(negedge clk);
                rsp_ready = 1'b1;
            end
        join
        chk("cmd2_accept_cycle", g_hs, resp_hs + 1);
        wait_done("backpressure");

        // Reset during WR_OP with stb high
        sl_delay = 3;
        push_wr(32'h1, 32'h2, 32'h3, 32'h0000_0005, 32'h0000_1055);
        bq[bq.size() - 1].ab = 2;
        send_cmd(32'h1, 32'h2, 32'h3, 3'd5, 12'h055);
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            #1;
            if (wbm_stb_o && wbm_we_o && wbm_adr_o == BASE + 32'h1C) break;
            n++;
        end
        if (n >= 400) fail_now("reset_wrop_not_seen", n, 0);
        wb_rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_stb", {31'b0, wbm_stb_o}, 32'h0);
        chk("rst_mid_cyc", {31'b0, wbm_cyc_o}, 32'h0);
        chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_mid_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        wb_rst_i = 1'b0;
        sl_delay = 0;
        sl_result = 32'h4049_0FDB; sl_flags = 32'h0000_0003;
        push_seq(32'h4049_0FDB, 32'h3F80_0000, 32'h0, 32'h0000_0000,
                 32'h0000_1008, 32'h0000_0008, 1,
                 32'h4049_0FDB, 5'h03, 17);
        send_cmd(32'h4049_0FDB, 32'h3F80_0000, 32'h0, 3'd0, 12'h008);
        wait_done("after_reset");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpu_wb_cmd_master.md
Name: fpu_wb_cmd_master

Overview:
- Wishbone classic initiator that drives the FPU user-project register file from a simple command/response interface, so an on-chip requester can run FPU operations without firmware.
- Takes one command (operands, rounding mode, opcode) and issues the register writes, including the operation-register write that sets the launch/valid bit.
- Polls status, reads back result and exception flags, then clears the valid bit.
- Sits between a command source and the user-project Wishbone slave port.

Parameters:
- BASE_ADDR, 32'h3000_0000, FPU register base. Offsets: a=0x00, b=0x04, c=0x08, result=0x0C, flags=0x10, op=0x1C, status=0x20, rm=0x24.
- ACK_TIMEOUT, 255, maximum cycles stb may stay high without wbm_ack_i before abort.
- POLL_LIMIT, 1023, maximum status reads before abort.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_a / cmd_b / cmd_c  in  32 each  operands.
- cmd_rm  in  3  rounding mode.
- cmd_op  in  12  opcode field.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_result  out  32  FPU result.
- rsp_flags  out  5  exception flags (flags reg [4:0]).
- rsp_err  out  1  bus timeout or poll limit hit.
- busy  out  1  state != IDLE.
- wbm_cyc_o / wbm_stb_o / wbm_we_o  out  1 each  Wishbone controls.
- wbm_sel_o  out  4  always 4'hF while stb high, else 0.
- wbm_adr_o / wbm_dat_o  out  32 each  address / write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  slave acknowledge.

Behaviour:
- Reset:
  - All outputs 0; cmd_ready=0 during the reset cycle, then 1 in IDLE.
  - Latched command discarded; timeout and poll counters 0.
  - Reset mid-transfer drops cyc/stb at the next edge; no completion of the in-flight transfer.
- All Wishbone outputs are registered.
- cmd_ready=1 only in IDLE. On handshake, latch a, b, c, rm, op; go to WR_A.
- Sequence: IDLE -> WR_A -> WR_B -> WR_C -> WR_RM -> WR_OP -> POLL -> RD_RES -> RD_FLG -> WR_CLR -> RESP -> IDLE.
- Write data:
  - WR_RM writes {29'b0, rm}.
  - WR_OP writes {19'b0, 1'b1, op} (bit 12 = valid).
  - WR_CLR writes {19'b0, 1'b0, op}.
- Transfer timing:
  - Each state asserts cyc=stb=1 with we/adr/dat set and holds them until the first cycle wbm_ack_i=1.
  - The next edge drops cyc/stb for exactly one idle cycle; the following transfer starts one cycle later.
  - With an always-acking slave, each transfer takes 2 cycles. Minimum latency from cmd handshake to rsp_valid is 17 cycles when status is ready on the first poll.
- POLL:
  - Read BASE+0x20. If wbm_dat_i[0]=1 on ack, go to RD_RES; otherwise issue another read after the idle cycle.
  - Poll counter increments per completed read. When the counter reaches POLL_LIMIT with bit0 still 0, abort.
- Reads: RD_RES captures wbm_dat_i into rsp_result on ack; RD_FLG captures wbm_dat_i[4:0] into rsp_flags.
- Timeout:
  - Counter resets at each transfer start and increments each cycle stb=1 && !ack.
  - At ACK_TIMEOUT: drop cyc/stb, skip remaining transfers including WR_CLR, go to RESP with rsp_err=1, rsp_result=0, rsp_flags=0.
  - The poll-limit abort behaves identically.
- RESP:
  - rsp_valid=1; outputs held stable until rsp_ready.
  - Handshake cycle -> IDLE, with rsp_valid=0 and cmd_ready=1 on the next cycle.
  - rsp_err is cleared on the next command accept.
- An ack arriving while stb=0 is ignored.
- cmd_valid during busy is not accepted and is not lost; it is taken when IDLE returns.

Test Plan:
- Nominal divide:
  - Stimulus: a=32'h40400000, b=32'h40000000, c=0, rm=0, op=12'h010; slave acks immediately; status=1 on first poll; result reg=32'h3FC00000, flags=0.
  - Required: write sequence adr 0x30000000/04/08/24/1C with op dat=32'h00001010; reads at 0x20/0x0C/0x10; clear write dat=32'h00000010; rsp_result=32'h3FC00000, rsp_err=0, rsp_valid at cycle 17.
- Wait states: slave delays each ack by 3 cycles and status reads 0 twice before 1 -> stb held stable during each wait, 3 POLL reads occur, and the result is unchanged.
- Ack timeout: no ack on the WR_B transfer -> cyc/stb drop after 255 cycles, rsp_err=1, rsp_result=0, no further bus cycles.
- Poll limit: status is never set -> exactly 1023 status reads, then rsp_err=1.
- Response backpressure: hold rsp_ready=0 for 10 cycles while a second command is pending -> rsp fields stable, cmd_ready=0, the second command is accepted the cycle after the response handshake.
- Reset mid-operation: assert wb_rst_i during WR_OP with stb high -> cyc/stb=0 on the next edge, rsp_valid=0, and a new command runs correctly from WR_A.
